icache_dm_param: RTL and testbench

- Parametrised direct-mapped instruction cache; successor to the fixed instruction-cache slot in the cache wrapper.
- CPU side is the SRAM-like fetch port with a stall output.
- Memory side is the arbiter word port, using a req/dok handshake.
- Adds configurable set count and line length, multi-word line refill, flush, and an optional uncached bypass.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_refill_ctrl.sv | 122 ++++++++++++
 rtl/icache_dm_param.sv | 128 ++++++++++++
 tb/tb_icache_dm_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and width helpers for the direct-mapped icache.
// Holds refill FSM states, derived address-field widths and the kseg1 prefix.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REFILL   = 2'd1,
      UNCACHED = 2'd2
   } state_e;

   localparam logic [2:0] KSEG1_PREFIX = 3'b101;

   function automatic int off_w(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int sets, input int line_words);
      return 32 - idx_w(sets) - off_w(line_words);
   endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: refill FSM, word counter, kill flag, memory req/addr.
// In: start_fill/start_unc/flush/dok, fetch_addr. Out: state, cnt, mem_req/addr,
// fill_we/fill_last/fill_kill strobes, unc_we. Bypass path under ICACHE_UNCACHED_EN.
module icache_refill_ctrl
   import icache_pkg::*;
#(
   parameter int LINE_WORDS = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          start_fill,
   input  logic                          start_unc,
   input  logic                          flush,
   input  logic                          dok,
   input  logic [31:0]                   fetch_addr,
   output state_e                        state,
   output logic [$clog2(LINE_WORDS)-1:0] cnt,
   output logic                          mem_req,
   output logic [31:0]                   mem_addr,
   output logic                          fill_we,
   output logic                          fill_last,
   output logic                          fill_kill,
   output logic                          unc_we
);

   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int WRD_W = OFF_W - 2;
   localparam logic [WRD_W-1:0] LAST = WRD_W'(LINE_WORDS - 1);

   state_e            state_q, state_d;
   logic [WRD_W-1:0]  cnt_q, cnt_d;
   logic              kill_q, kill_d;
   logic              req_q, req_d;
   logic [31:0]       addr_q, addr_d;
   logic              fill_dok;

   assign fill_dok = (state_q == REFILL) && dok;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kill_d  = kill_q;
      req_d   = req_q;
      addr_d  = addr_q;
      unique case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (start_fill) begin
               state_d = REFILL;
               cnt_d   = '0;
               req_d   = 1'b1;
               addr_d  = {fetch_addr[31:OFF_W], {OFF_W{1'b0}}};
            end
`ifdef ICACHE_UNCACHED_EN
            else if (start_unc) begin
               state_d = UNCACHED;
               req_d   = 1'b1;
               addr_d  = fetch_addr;
            end
`endif
         end
         REFILL: begin
            // a flush mid-burst lets the burst finish but blocks validation
            if (flush) kill_d = 1'b1;
            if (dok) begin
               if (cnt_q == LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  kill_d  = 1'b0;
                  req_d   = 1'b0;
               end else begin
                  cnt_d  = cnt_q + WRD_W'(1);
                  addr_d = addr_q + 32'd4;
               end
            end
         end
`ifdef ICACHE_UNCACHED_EN
         UNCACHED: begin
            if (dok) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         kill_q  <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kill_q  <= kill_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
      end
   end

   assign state     = state_q;
   assign cnt       = cnt_q;
   assign mem_req   = req_q;
   assign mem_addr  = addr_q;
   assign fill_we   = fill_dok;
   assign fill_last = fill_dok && (cnt_q == LAST);
   // flush on the last dok itself must also keep the line invalid
   assign fill_kill = kill_q | flush;

`ifdef ICACHE_UNCACHED_EN
   assign unc_we = (state_q == UNCACHED) && dok;
`else
   logic unused_ok;
   assign unused_ok = ^{start_unc, fetch_addr[OFF_W-1:0]};
   assign unc_we    = 1'b0;
`endif

endmodule

// File: rtl/icache_dm_param.sv
// icache_dm_param: parametrised direct-mapped icache, zero-cycle hit, line refill.
// CPU: inst_sram_en/addr/rdata, i_stall, cache_flush. Mem: inst_cache_req/addr/rdata/dok.
// Optional kseg1 uncached bypass when ICACHE_UNCACHED_EN is defined.
module icache_dm_param
   import icache_pkg::*;
#(
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_en,
   input  logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_rdata,
   output logic        i_stall,
   input  logic        cache_flush,
   output logic        inst_cache_req,
   output logic [31:0] inst_cache_addr,
   input  logic [31:0] inst_cache_rdata,
   input  logic        inst_cache_dok
);

   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(SETS, LINE_WORDS);
   localparam int WRD_W = OFF_W - 2;

   logic [31:0]      data_q [SETS*LINE_WORDS];
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [SETS-1:0]  valid_q, valid_d;

   logic [IDX_W-1:0] idx, widx;
   logic [WRD_W-1:0] wrd, cnt;
   logic [TAG_W-1:0] tag;
   logic [31:0]      rd_word;
   state_e           state;
   logic             idle, hit, byp, unc_rdy;
   logic             start_fill, start_unc;
   logic             fill_we, fill_last, fill_kill, unc_we;

   assign idx  = inst_sram_addr[IDX_W+OFF_W-1:OFF_W];
   assign wrd  = inst_sram_addr[OFF_W-1:2];
   assign tag  = inst_sram_addr[31:IDX_W+OFF_W];
   // refill target line comes from the latched request address
   assign widx = inst_cache_addr[IDX_W+OFF_W-1:OFF_W];
   assign idle = (state == IDLE);

   assign hit = inst_sram_en && !byp && valid_q[idx] && (tag_q[idx] == tag);
   assign start_fill = idle && inst_sram_en && !byp && !hit;
   assign i_stall = !idle || (inst_sram_en && !hit && !unc_rdy);
   assign rd_word = data_q[{idx, wrd}];

   icache_refill_ctrl #(
      .LINE_WORDS(LINE_WORDS)
   ) u_ctrl (
      .clk        (clk),
      .resetn     (resetn),
      .start_fill (start_fill),
      .start_unc  (start_unc),
      .flush      (cache_flush),
      .dok        (inst_cache_dok),
      .fetch_addr (inst_sram_addr),
      .state      (state),
      .cnt        (cnt),
      .mem_req    (inst_cache_req),
      .mem_addr   (inst_cache_addr),
      .fill_we    (fill_we),
      .fill_last  (fill_last),
      .fill_kill  (fill_kill),
      .unc_we     (unc_we)
   );

   always_comb begin
      valid_d = valid_q;
      // line being overwritten must not hit on its stale tag
      if (start_fill) valid_d[idx] = 1'b0;
      if (cache_flush) valid_d = '0;
      if (fill_last && !fill_kill) valid_d[widx] = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) valid_q <= '0;
      else valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (fill_we) data_q[{widx, cnt}] <= inst_cache_rdata;
      if (fill_last) tag_q[widx] <= inst_cache_addr[31:IDX_W+OFF_W];
   end

`ifdef ICACHE_UNCACHED_EN
   logic [31:0] hold_q, hold_d;
   logic        urdy_q, urdy_d;

   assign byp = inst_sram_en && (inst_sram_addr[31:29] == KSEG1_PREFIX);
   assign unc_rdy = urdy_q && byp;
   assign start_unc = idle && byp && !urdy_q;

   always_comb begin
      hold_d = hold_q;
      if (unc_we) hold_d = inst_cache_rdata;
      urdy_d = unc_we;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_q <= '0;
         urdy_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         urdy_q <= urdy_d;
      end
   end

   assign inst_sram_rdata = unc_rdy ? hold_q : rd_word;
`else
   logic unused_unc;
   assign unused_unc      = unc_we;
   assign byp             = 1'b0;
   assign unc_rdy         = 1'b0;
   assign start_unc       = 1'b0;
   assign inst_sram_rdata = rd_word;
`endif

   logic unused_ok;
   assign unused_ok = ^{inst_sram_addr[1:0], inst_cache_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_icache_dm_param.sv
// tb_icache_dm_param: self-checking bench for icache_dm_param (SETS=64, LINE_WORDS=4).
// Memory model returns addr^salt after a programmable dok delay.
module tb_icache_dm_param;

   logic        clk = 1'b0;
   logic        resetn, en, flush, req, dok;
   logic [31:0] addr, rdata, maddr, mrdata;
   logic        stall;

   icache_dm_param #(
      .SETS(64),
      .LINE_WORDS(4)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .inst_sram_en     (en),
      .inst_sram_addr   (addr),
      .inst_sram_rdata  (rdata),
      .i_stall          (stall),
      .cache_flush      (flush),
      .inst_cache_req   (req),
      .inst_cache_addr  (maddr),
      .inst_cache_rdata (mrdata),
      .inst_cache_dok   (dok)
   );

   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_chk = 0;
   logic [31:0] salt = 32'h1111_0000;
   int          mem_delay = 0;
   int          dok_cnt = 0;
   int          wcnt = 0;
   int          d0, n0;
   bit          unstable = 1'b0;
   logic [31:0] waddr;
   logic [31:0] req_log[$];
   logic [31:0] exp_req[$];
   logic [31:0] sb[$];

   typedef struct {
      logic [31:0] a;
      int          lat;
   } vec_t;
   vec_t tab[9];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // memory side: answers each req after mem_delay wait cycles
   initial begin
      dok = 1'b0;
      mrdata = '0;
      forever begin
         @(negedge clk);
         dok = 1'b0;
         if (!resetn) begin
            wcnt = 0;
         end else if (req) begin
            if (wcnt == 0) waddr = maddr;
            else if (maddr != waddr) unstable = 1'b1;
            if (wcnt >= mem_delay) begin
               dok = 1'b1;
               mrdata = maddr ^ salt;
               req_log.push_back(maddr);
               dok_cnt++;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else if (wcnt != 0) begin
            unstable = 1'b1;
            wcnt = 0;
         end
      end
   end

   task automatic fetch(input logic [31:0] a, input int exp_lat,
                        input string nm);
      int lat;
      logic [31:0] e;
      @(negedge clk);
      en = 1'b1;
      addr = a;
      sb.push_back(a ^ salt);
      #1;
      lat = 0;
      while (stall && lat < 300) begin
         @(negedge clk);
         #1;
         lat++;
      end
      e = sb.pop_front();
      if (stall) begin
         check({nm, " timeout stall"}, {31'b0, stall}, 32'd0);
      end else begin
         check({nm, " rdata"}, rdata, e);
         if (exp_lat >= 0) check({nm, " latency"}, 32'(lat), 32'(exp_lat));
      end
      @(posedge clk);
      #1;
      en = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      en = 1'b0;
      flush = 1'b0;
      addr = '0;
      #3;
      check("reset stall", {31'b0, stall}, 32'd0);
      check("reset req", {31'b0, req}, 32'd0);
      check("reset maddr", maddr, 32'd0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // cold miss, hits, conflict eviction, re-miss
      tab[0] = '{32'h9FC00018, 5};
      tab[1] = '{32'h9FC0001C, 0};
      tab[2] = '{32'h9FC00010, 0};
      tab[3] = '{32'h9FC00014, 0};
      tab[4] = '{32'h9FC00410, 5};
      tab[5] = '{32'h9FC0041C, 0};
      tab[6] = '{32'h9FC00010, 5};
      tab[7] = '{32'h9FC00020, 5};
      tab[8] = '{32'h9FC00010, 0};
      for (int i = 0; i < 9; i++) begin
         if (tab[i].lat > 0)
            for (int w = 0; w < 4; w++)
               exp_req.push_back({tab[i].a[31:4], 4'h0} + 32'(4 * w));
         fetch(tab[i].a, tab[i].lat, $sformatf("vec%0d", i));
      end
      check("req count", 32'(req_log.size()), 32'(exp_req.size()));
      for (int i = 0; i < exp_req.size() && i < req_log.size(); i++)
         check($sformatf("req%0d addr", i), req_log[i], exp_req[i]);

      // slow memory
      salt = 32'h2222_0000;
      mem_delay = 5;
      unstable = 1'b0;
      fetch(32'h9FC00804, 25, "slow miss");
      check("slow req/addr stable", {31'b0, unstable}, 32'd0);
      mem_delay = 0;
      fetch(32'h9FC00800, 0, "slow w0");
      fetch(32'h9FC00808, 0, "slow w2");
      fetch(32'h9FC0080C, 0, "slow w3");

      // flush mid-refill: burst completes, CPU re-misses
      salt = 32'h3333_0000;
      n0 = req_log.size();
      d0 = dok_cnt;
      fork
         fetch(32'h9FC01030, 10, "flush mid");
         begin
            for (int i = 0; i < 100 && dok_cnt < d0 + 2; i++)
               @(posedge clk);
            check("flush at 2nd dok", 32'(dok_cnt - d0), 32'd2);
            #2 flush = 1'b1;
            @(posedge clk);
            #2 flush = 1'b0;
         end
      join
      check("flush mid reqs", 32'(req_log.size() - n0), 32'd8);

      // flush in idle: flush-cycle lookup still hits, next fetch misses
      @(negedge clk);
      en = 1'b1;
      addr = 32'h9FC01030;
      flush = 1'b1;
      #1;
      check("flush cycle stall", {31'b0, stall}, 32'd0);
      check("flush cycle rdata", rdata, 32'h9FC01030 ^ salt);
      @(posedge clk);
      #1;
      flush = 1'b0;
      en = 1'b0;
      n0 = req_log.size();
      fetch(32'h9FC01030, 5, "after flush");
      check("after flush reqs", 32'(req_log.size() - n0), 32'd4);

      // reset mid-refill
      salt = 32'h4444_0000;
      @(negedge clk);
      en = 1'b1;
      addr = 32'h9FC00018;
      d0 = dok_cnt;
      for (int i = 0; i < 100 && dok_cnt < d0 + 2; i++)
         @(posedge clk);
      check("rst at 2nd dok", 32'(dok_cnt - d0), 32'd2);
      #2 resetn = 1'b0;
      #1;
      check("rst async req", {31'b0, req}, 32'd0);
      check("rst async maddr", maddr, 32'd0);
      en = 1'b0;
      #1;
      check("rst idle stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      n0 = req_log.size();
      fetch(32'h9FC00018, 5, "post reset");
      check("post reset req0",
            (req_log.size() > n0) ? req_log[n0] : 32'hDEAD_DEAD,
            32'h9FC00010);

`ifdef ICACHE_UNCACHED_EN
      // kseg1 bypass: one exact-address request per fetch, no allocation
      n0 = req_log.size();
      salt = 32'h5555_0000;
      fetch(32'hBFC00004, 2, "unc1");
      salt = 32'h6666_0000;
      fetch(32'hBFC00004, 2, "unc2");
      check("unc req count", 32'(req_log.size() - n0), 32'd2);
      for (int i = 0; i < 2 && n0 + i < req_log.size(); i++)
         check($sformatf("unc req%0d", i), req_log[n0 + i], 32'hBFC00004);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
